inst_fetch: RTL and testbench

Instruction fetch stage of the RV32I core: holds the PC, issues word-aligned read requests to instruction memory, buffers in-order responses in a small prefetch FIFO, and presents `{pc, inst}` pairs to decode, which forwards `inst` to the immediate generator and control decoder. A redirect from execute (branch, JAL, JALR) reloads the PC, flushes buffered words and discards responses still in flight.

---
 rtl/rv32_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/inst_fetch.sv | 141 ++++++++++++++
 tb/tb_inst_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: word widths, reset PC, canonical NOP and the
// {pc, inst} fetch packet carried from fetch to decode.
package rv32_pkg;

    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop, synchronous flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data = mem_q[rd_q];
    assign count     = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: PC, credit-limited imem requests, prefetch buffer and
// redirect flush. Optional perf counters when IFU_PERF_CNT_EN is defined.
module inst_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] buf_count, pcq_count;
    fetch_pkt_t    buf_head, buf_push_pkt;
    logic [31:0]   pcq_head;
    logic [CW:0]   inflight;
    logic          pop, req_fire, rsp_keep;

    assign pop       = out_valid && out_ready;
    assign out_valid = (buf_count != '0) && !redirect_valid;

    // Committed slots after this cycle's pop; a new request needs one spare.
    assign inflight       = (CW+1)'(outst_q) + (CW+1)'(buf_count) - (CW+1)'(pop);
    assign imem_req_valid = !rst && !redirect_valid && (inflight < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Only responses to requests issued since the last redirect are buffered.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_q == '0) && (pcq_count != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)
            fetch_pc_d = word_align(redirect_pc);
        else if (req_fire)
            fetch_pc_d = fetch_pc_q + 32'd4;

        case ({req_fire, imem_rsp_valid})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        drop_d = drop_q;
        if (redirect_valid)
            drop_d = outst_q - CW'(imem_rsp_valid);
        else if (imem_rsp_valid && (drop_q != '0))
            drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .head_data (pcq_head),
        .count     (pcq_count)
    );

    always_comb begin
        buf_push_pkt.pc   = pcq_head;
        buf_push_pkt.inst = imem_rsp_data;
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_pkt_t))) u_prefetch (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (buf_push_pkt),
        .pop       (pop),
        .head_data (buf_head),
        .count     (buf_count)
    );

    assign out_inst = (buf_count != '0) ? buf_head.inst : '0;
    assign out_pc   = (buf_count != '0) ? buf_head.pc   : RESET_PC;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] flush_inc;

    always_comb begin
        flush_inc = redirect_valid ? 32'(buf_count) : 32'd0;
        if (imem_rsp_valid && (redirect_valid || (drop_q != '0)))
            flush_inc = flush_inc + 32'd1;
        perf_fetched_d = perf_fetched_q + (pop ? 32'd1 : 32'd0);
        perf_flushed_d = perf_flushed_q + flush_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-configurable in-order memory
// model and a reference model of the expected request and delivery streams.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int cyc; } rec_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; } vec_t;

    rec_t  req_log[$];
    rec_t  dlv_log[$];
    pend_t pending[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int fetched_cnt = 0;

    logic        acc_now = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [31:0] exp_pc  = '0;
    logic [31:0] exp_req = '0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Memory: in-order, fixed latency 'lat' cycles after acceptance.
    always @(posedge clk) begin
        cyc++;
        if (rst) pending.delete();
        else if (acc_now) pending.push_back('{addr: acc_addr, due: cyc + lat});
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst && pending.size() > 0 && pending[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(pending[0].addr);
            void'(pending.pop_front());
        end
    end

    // Monitor: reference fetch PC and delivery PC streams.
    always @(negedge clk) begin
        acc_now  = !rst && imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (rst) begin
            exp_pc      = 32'h0;
            exp_req     = 32'h0;
            fetched_cnt = 0;
        end else begin
            if (redirect_valid) begin
                chk("redir_out_valid", {31'b0, out_valid}, 32'd0);
                chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end else begin
                if (out_valid && out_ready) begin
                    chk("out_pc_seq", out_pc, exp_pc);
                    chk("out_inst", out_inst, inst_of(exp_pc));
                    dlv_log.push_back('{addr: out_pc, cyc: cyc});
                    exp_pc = exp_pc + 32'd4;
                    fetched_cnt++;
                end
                if (acc_now) begin
                    chk("req_addr_seq", imem_req_addr, exp_req);
                    req_log.push_back('{addr: imem_req_addr, cyc: cyc});
                    exp_req = exp_req + 32'd4;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step(3);
        req_log.delete();
        dlv_log.delete();
        rst = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int nr, nd, k;
        vecs[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200};
        vecs[1] = '{rpc: 32'h0000_1001, exp_addr: 32'h0000_1000};
        vecs[2] = '{rpc: 32'h0000_0010, exp_addr: 32'h0000_0010};
        vecs[3] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
        vecs[4] = '{rpc: 32'h8000_0042, exp_addr: 32'h8000_0040};

        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset state
        step(2);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);

        // Streaming, L=1
        lat = 1;
        do_reset();
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        step(10);
        if (req_log.size() >= 3 && dlv_log.size() >= 3) begin
            chk("t1_req0", req_log[0].addr, 32'h0);
            chk("t1_req1", req_log[1].addr, 32'h4);
            chk("t1_req2", req_log[2].addr, 32'h8);
            chk("t1_req_gap", 32'(req_log[2].cyc - req_log[0].cyc), 32'd2);
            chk("t1_dlv0", dlv_log[0].addr, 32'h0);
            chk("t1_dlv2", dlv_log[2].addr, 32'h8);
            chk("t1_dlv_gap", 32'(dlv_log[2].cyc - dlv_log[0].cyc), 32'd2);
            chk("t1_latency", 32'(dlv_log[0].cyc - req_log[0].cyc), 32'd2);
        end else begin
            chk("t1_log_size", 32'(dlv_log.size()), 32'd3);
        end

        // Asynchronous reset mid-stream clears outputs at once
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Decode stall
        out_ready = 1'b0;
        do_reset();
        step(10);
        #1;
        chk("t2_req_count", 32'(req_log.size()), 32'd2);
        chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_out_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        step(10);
        if (dlv_log.size() >= 3) begin
            chk("t2_dlv0", dlv_log[0].addr, 32'h0);
            chk("t2_dlv1", dlv_log[1].addr, 32'h4);
            chk("t2_dlv2", dlv_log[2].addr, 32'h8);
            chk("t2_no_gap", 32'(dlv_log[2].cyc - dlv_log[0].cyc), 32'd2);
        end else begin
            chk("t2_log_size", 32'(dlv_log.size()), 32'd3);
        end

        // L=3, redirect with two requests outstanding
        lat = 3;
        do_reset();
        for (k = 0; k < 20; k++) begin
            if (pending.size() == 2) break;
            step(1);
        end
        chk("t3_outstanding", 32'(pending.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step(1);
        redirect_valid = 1'b0;
        nr = req_log.size();
        nd = dlv_log.size();
        step(15);
        chk("t3_drop_zero", 32'(dut.drop_q), 32'd0);
        if (dlv_log.size() > nd && req_log.size() > nr) begin
            chk("t3_req_after", req_log[nr].addr, 32'h100);
            chk("t3_dlv_after", dlv_log[nd].addr, 32'h100);
        end else begin
            chk("t3_progress", 32'(dlv_log.size()), 32'(nd + 1));
        end

        // Redirect vectors, each coinciding with a response in L=1 streaming
        lat = 1;
        do_reset();
        step(5);
        for (int i = 0; i < 5; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk("vec_rsp_same_cycle", {31'b0, imem_rsp_valid}, 32'd1);
            chk("vec_out_valid_redir", {31'b0, out_valid}, 32'd0);
            step(1);
            redirect_valid = 1'b0;
            nr = req_log.size();
            nd = dlv_log.size();
            step(6);
            if (req_log.size() > nr && dlv_log.size() > nd + 1) begin
                chk("vec_req_addr", req_log[nr].addr, vecs[i].exp_addr);
                chk("vec_out_pc", dlv_log[nd].addr, vecs[i].exp_addr);
                chk("vec_out_pc_next", dlv_log[nd + 1].addr, vecs[i].exp_addr + 32'd4);
            end else begin
                chk("vec_progress", 32'(dlv_log.size()), 32'(nd + 2));
            end
        end

        // Mixed back-pressure with periodic redirects, L=2
        lat = 2;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            imem_req_ready = 1'($urandom_range(0, 3) != 0);
            out_ready      = 1'($urandom_range(0, 2) != 0);
            redirect_valid = (i % 17) == 16;
            redirect_pc    = $urandom & 32'h0000_FFFF;
            step(1);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        nd = dlv_log.size();
        step(10);
        chk("mix_progress", {31'b0, dlv_log.size() > nd}, 32'd1);
        chk("mix_drop_zero", 32'(dut.drop_q), 32'd0);

`ifdef IFU_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(fetched_cnt));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
